ras_circular_stack: RTL and testbench

- Return-address stack for the frontend branch predictor. Sized from the core configuration's RAS depth (default 2 for the 32-bit IMAC, no-virtual-memory core).
- Consumes call/return indications from the predecode/branch-predict stage. Supplies the predicted return target to the next-PC selection logic.
- Overflow silently discards the oldest entry by circular overwrite. Mispredict flush empties the stack.

---
 rtl/ras_circular_stack.sv | 71 +++++++
 tb/tb_ras_circular_stack.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_circular_stack.sv
// Return-address stack for the frontend predictor: circular buffer of call
// return targets where overflow overwrites the oldest entry.
module ras_circular_stack #(
  parameter  int DEPTH = 2,
  parameter  int VLEN  = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic            top_valid_o,
  output logic [VLEN-1:0] top_addr_o,
  output logic [CW-1:0]   count_o
);

  logic [VLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_tp;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_tpInc;
  logic [PW-1:0]   w_tpDec;
  logic            w_empty;
  logic            w_full;
  logic            w_doPush;
  logic            w_doSwap;
  logic            w_doPop;

  // Explicit wrap compares so non-power-of-two depths stay within 0..DEPTH-1.
  assign w_tpInc = (r_tp == PW'(DEPTH - 1)) ? '0 : r_tp + 1'b1;
  assign w_tpDec = (r_tp == '0) ? PW'(DEPTH - 1) : r_tp - 1'b1;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_doPush = !flush_i && push_i && (!pop_i || w_empty);
  assign w_doSwap = !flush_i && push_i && pop_i && !w_empty;
  assign w_doPop  = !flush_i && !push_i && pop_i && !w_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (flush_i) begin
        r_cnt <= '0;
      end else if (w_doPush) begin
        r_tp           <= w_tpInc;
        r_mem[w_tpInc] <= data_i;
        if (!w_full) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_doSwap) begin
        r_mem[r_tp] <= data_i;
      end else if (w_doPop) begin
        r_tp  <= w_tpDec;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign top_valid_o = !w_empty;
  assign top_addr_o  = r_mem[r_tp];
  assign count_o     = r_cnt;

endmodule

// File: tb/tb_ras_circular_stack.sv
// Bench for ras_circular_stack: DEPTH 2, 3 and 1 instances share one stimulus
// stream and are each compared against a linear-stack model every cycle.
module tb_ras_circular_stack;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        push_i;
  logic        pop_i;
  logic [31:0] data_i;

  logic        valid2, valid3, valid1;
  logic [31:0] addr2, addr3, addr1;
  logic [1:0]  cnt2;
  logic [1:0]  cnt3;
  logic [0:0]  cnt1;

  logic        dutValid [3];
  logic [31:0] dutAddr  [3];
  logic [31:0] dutCnt   [3];

  int          checks;
  int          failures;
  bit          compareEn;

  int          mDepth [3];
  int          mCnt   [3];
  logic [31:0] mStk   [3][3];

  ras_circular_stack #(.DEPTH(2), .VLEN(32)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
    .data_i(data_i), .top_valid_o(valid2), .top_addr_o(addr2), .count_o(cnt2));

  ras_circular_stack #(.DEPTH(3), .VLEN(32)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
    .data_i(data_i), .top_valid_o(valid3), .top_addr_o(addr3), .count_o(cnt3));

  ras_circular_stack #(.DEPTH(1), .VLEN(32)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
    .data_i(data_i), .top_valid_o(valid1), .top_addr_o(addr1), .count_o(cnt1));

  assign dutValid[0] = valid2;
  assign dutValid[1] = valid3;
  assign dutValid[2] = valid1;
  assign dutAddr[0]  = addr2;
  assign dutAddr[1]  = addr3;
  assign dutAddr[2]  = addr1;
  assign dutCnt[0]   = {30'd0, cnt2};
  assign dutCnt[1]   = {30'd0, cnt3};
  assign dutCnt[2]   = {31'd0, cnt1};

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model is a plain bottom-anchored stack; overflow shifts out the oldest entry.
  task automatic modelStep(input bit f, input bit pu, input bit po, input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      if (f) begin
        mCnt[i] = 0;
      end else if (pu && po && mCnt[i] > 0) begin
        mStk[i][mCnt[i]-1] = d;
      end else if (pu) begin
        if (mCnt[i] < mDepth[i]) begin
          mStk[i][mCnt[i]] = d;
          mCnt[i]++;
        end else begin
          for (int k = 0; k < mDepth[i] - 1; k++) mStk[i][k] = mStk[i][k+1];
          mStk[i][mDepth[i]-1] = d;
        end
      end else if (po && mCnt[i] > 0) begin
        mCnt[i]--;
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) mCnt[i] = 0;
  endtask

  task automatic applyStimulus(input bit f, input bit pu, input bit po, input logic [31:0] d);
    flush_i = f;
    push_i  = pu;
    pop_i   = po;
    data_i  = d;
    @(posedge clk_i);
    modelStep(f, pu, po, d);
    #1;
    flush_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    data_i  = 32'h0;
  endtask

  always @(negedge clk_i) begin
    if (compareEn && !rst_i) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("d%0d_valid", mDepth[i]), {31'd0, dutValid[i]}, (mCnt[i] > 0) ? 32'd1 : 32'd0);
        checkOutput($sformatf("d%0d_count", mDepth[i]), dutCnt[i], 32'(mCnt[i]));
        if (mCnt[i] > 0)
          checkOutput($sformatf("d%0d_top", mDepth[i]), dutAddr[i], mStk[i][mCnt[i]-1]);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    compareEn = 1'b0;
    mDepth[0] = 2;
    mDepth[1] = 3;
    mDepth[2] = 1;
    modelReset();
    rst_i   = 1'b1;
    flush_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    data_i  = 32'h0;

    #2;
    checkOutput("inreset_valid2", {31'd0, valid2}, 32'd0);
    checkOutput("inreset_addr2", addr2, 32'h0);
    checkOutput("inreset_count2", {30'd0, cnt2}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    compareEn = 1'b1;

    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("idle_valid2", {31'd0, valid2}, 32'd0);
    checkOutput("idle_addr2", addr2, 32'h0);
    checkOutput("idle_count3", {30'd0, cnt3}, 32'd0);

    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("underflow_valid2", {31'd0, valid2}, 32'd0);
    checkOutput("underflow_addr2", addr2, 32'h0);
    checkOutput("underflow_count2", {30'd0, cnt2}, 32'd0);

    applyStimulus(0, 1, 0, 32'h100);
    applyStimulus(0, 1, 0, 32'h200);
    checkOutput("push2_count2", {30'd0, cnt2}, 32'd2);
    checkOutput("push2_top2", addr2, 32'h200);
    checkOutput("push2_count1", {31'd0, cnt1}, 32'd1);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("pop_top2", addr2, 32'h100);
    checkOutput("pop_count2", {30'd0, cnt2}, 32'd1);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("pop_empty_valid2", {31'd0, valid2}, 32'd0);
    checkOutput("pop_empty_count2", {30'd0, cnt2}, 32'd0);

    applyStimulus(0, 1, 0, 32'h100);
    applyStimulus(0, 1, 0, 32'h200);
    applyStimulus(0, 1, 0, 32'h300);
    checkOutput("ovf_count2", {30'd0, cnt2}, 32'd2);
    checkOutput("ovf_top2", addr2, 32'h300);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("ovf_pop_top2", addr2, 32'h200);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("ovf_lost_valid2", {31'd0, valid2}, 32'd0);
    checkOutput("ovf_top3", addr3, 32'h100);
    applyStimulus(1, 0, 0, 32'h0);

    applyStimulus(0, 1, 0, 32'h100);
    applyStimulus(0, 1, 0, 32'h200);
    applyStimulus(0, 1, 1, 32'h400);
    checkOutput("swap_top2", addr2, 32'h400);
    checkOutput("swap_count2", {30'd0, cnt2}, 32'd2);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("swap_pop_top2", addr2, 32'h100);
    applyStimulus(1, 0, 0, 32'h0);

    applyStimulus(0, 1, 1, 32'h500);
    checkOutput("swap_empty_count2", {30'd0, cnt2}, 32'd1);
    checkOutput("swap_empty_top2", addr2, 32'h500);
    applyStimulus(1, 1, 0, 32'h600);
    checkOutput("flush_push_count2", {30'd0, cnt2}, 32'd0);
    checkOutput("flush_push_valid2", {31'd0, valid2}, 32'd0);

    for (int k = 1; k <= 5; k++) applyStimulus(0, 1, 0, 32'(k * 16));
    checkOutput("d3_fill_count", {30'd0, cnt3}, 32'd3);
    checkOutput("d3_fill_top", addr3, 32'h50);
    checkOutput("d1_fill_count", {31'd0, cnt1}, 32'd1);
    checkOutput("d1_fill_top", addr1, 32'h50);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("d3_pop1_top", addr3, 32'h40);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("d3_pop2_top", addr3, 32'h30);
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("d3_pop3_valid", {31'd0, valid3}, 32'd0);

    applyStimulus(0, 1, 0, 32'h77);
    applyStimulus(0, 1, 0, 32'h88);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_valid3", {31'd0, valid3}, 32'd0);
    checkOutput("async_count3", {30'd0, cnt3}, 32'd0);
    checkOutput("async_addr3", addr3, 32'h0);
    checkOutput("async_addr2", addr2, 32'h0);
    modelReset();
    rst_i = 1'b0;

    applyStimulus(0, 1, 0, 32'h99);
    checkOutput("post_reset_top2", addr2, 32'h99);

    for (int k = 0; k < 200; k++) begin
      applyStimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFE);
    end

    @(negedge clk_i);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
